// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a sequential PC, start/branch
// redirects (absolute or PC-relative), a req/ack instruction-memory port
// and a DEPTH-entry FIFO of {pc, instruction} pairs feeding decode.
//
// Optional build macro FETCH_STATS_EN adds saturating counters for
// instructions handed to decode (fetched_cnt_o) and redirects taken while
// fetching (flush_cnt_o).
//
// Handshakes:
//   imem port : imem_req_o/imem_addr_o come straight from registers. Once
//               imem_req_o is high it and imem_addr_o hold until the cycle
//               imem_ack_i is seen; imem_ack_i while imem_req_o is low is
//               ignored. An ack completes the transfer in that same cycle.
//   decode    : instr_valid_o/instr_ready_i is valid/ready; a word moves
//               when both are high at a rising edge. A redirect flushes the
//               FIFO at that edge and voids any simultaneous pop.
// dbg_state_o exposes the FSM state (0 IDLE, 1 RUN, 2 DRAIN) for checkers.
module fetch_unit #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [PC_W-1:0]    start_address_i,
  input  logic               branch_i,
  input  logic               branch_rel_i,
  input  logic [PC_W-1:0]    branch_pc_i,
  input  logic [PC_W-1:0]    branchloc_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    instr_pc_o,
  input  logic               instr_ready_i,
  output logic [PC_W-1:0]    pc_o,
`ifdef FETCH_STATS_EN
  output logic [31:0]        fetched_cnt_o,
  output logic [15:0]        flush_cnt_o,
`endif
  output logic [1:0]         dbg_state_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  // Control state
  logic [1:0]       r_state;
  logic [PC_W-1:0]  r_fetch_pc;
  logic [PC_W-1:0]  r_target;
  logic             r_req;

  // FIFO state
  logic [INSTR_W-1:0] r_fifo_data [DEPTH];
  logic [PC_W-1:0]    r_fifo_pc   [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  // Combinational next-state values
  logic [1:0]       w_state_nxt;
  logic [PC_W-1:0]  w_fetch_pc_nxt;
  logic [PC_W-1:0]  w_target_nxt;
  logic             w_req_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  logic             w_redirect;
  logic [PC_W-1:0]  w_target;
  logic             w_flush;
  logic             w_ack;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;

  // Redirect target: start wins over branch; sums wrap modulo 2^PC_W, which
  // also makes a two's-complement offset behave as a signed displacement.
  always_comb begin
    w_redirect = start_i | branch_i;
    if (start_i) begin
      w_target = start_address_i;
    end else if (branch_rel_i) begin
      w_target = branch_pc_i + branchloc_i;
    end else begin
      w_target = branchloc_i;
    end
  end

  // Transfer qualifiers for the memory port and the FIFO
  always_comb begin
    w_flush = (r_state != S_IDLE) & w_redirect;
    w_ack   = r_req & imem_ack_i;
    w_push  = (r_state == S_RUN) & w_ack & ~w_redirect;
    w_valid = (r_count != '0);
    w_pop   = w_valid & instr_ready_i & ~w_flush;
    if (w_flush) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, w_push}
                            - {{(CNT_W-1){1'b0}}, w_pop};
    end
  end

  // Fetch FSM next-state, next PC, saved target and next request
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_target_nxt   = r_target;
    w_req_nxt      = r_req;
    case (r_state)
      S_IDLE: begin
        // Branches are meaningless before fetching starts.
        w_req_nxt = 1'b0;
        if (start_i) begin
          w_state_nxt    = S_RUN;
          w_fetch_pc_nxt = start_address_i;
          w_req_nxt      = 1'b1;
        end
      end
      S_RUN: begin
        if (w_redirect) begin
          if (r_req && !imem_ack_i) begin
            // Outstanding read must complete at its old address first.
            w_state_nxt  = S_DRAIN;
            w_target_nxt = w_target;
            w_req_nxt    = 1'b1;
          end else begin
            // No read in flight (or it completes now and is dropped).
            w_fetch_pc_nxt = w_target;
            w_req_nxt      = 1'b1;
          end
        end else if (r_req && !imem_ack_i) begin
          w_req_nxt = 1'b1;
        end else begin
          if (w_ack) begin
            w_fetch_pc_nxt = r_fetch_pc + PC_ONE;
          end
          w_req_nxt = (w_count_nxt < DEPTH_C);
        end
      end
      S_DRAIN: begin
        if (w_redirect) begin
          w_target_nxt = w_target;
        end
        if (imem_ack_i) begin
          // Stale data is dropped; the newest target takes effect.
          w_state_nxt    = S_RUN;
          w_fetch_pc_nxt = w_redirect ? w_target : r_target;
          w_req_nxt      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_target   <= RESET_PC;
      r_req      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_target   <= w_target_nxt;
      r_req      <= w_req_nxt;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_ONE;
        end
      end
    end
  end

  // FIFO storage; contents are only observed through a valid head
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_rdata_i;
      r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetched_cnt;
  logic [15:0] r_flush_cnt;

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetched_cnt <= '0;
      r_flush_cnt   <= '0;
    end else begin
      if (w_pop && (r_fetched_cnt != '1)) begin
        r_fetched_cnt <= r_fetched_cnt + 32'd1;
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign fetched_cnt_o = r_fetched_cnt;
  assign flush_cnt_o   = r_flush_cnt;
`endif

  // Output drive; head fields read as zero when the FIFO is empty
  always_comb begin
    imem_req_o    = r_req;
    imem_addr_o   = r_fetch_pc;
    pc_o          = r_fetch_pc;
    instr_valid_o = w_valid;
    instr_o       = w_valid ? r_fifo_data[r_rd_ptr] : '0;
    instr_pc_o    = w_valid ? r_fifo_pc[r_rd_ptr] : '0;
    dbg_state_o   = r_state;
  end

endmodule
